// File: rtl/dec_pipe.sv
// dec_pipe: single registered instruction-decode stage with run/drain/halted control (DEC_PIPE_IMM_EN enables immediate classes)
module dec_pipe #(
    parameter int IB_W     = 8,
    parameter int ILL_HALT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     ins,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [1:0]      aradr,
    output logic [1:0]      bradr,
    output logic [1:0]      wadr,
    output logic [2:0]      op,
    output logic            we,
    output logic            halt,
    output logic            ll,
    output logic            lh,
    output logic            use_imm,
    output logic [IB_W-1:0] ib,
    output logic            halted,
    output logic            illegal
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
    state_t state, state_nx;
    logic [2:0]      cls;
    logic [1:0]      d_aradr, d_bradr, d_wadr;
    logic [2:0]      d_op;
    logic            d_we, d_halt, d_ll, d_lh, d_use_imm, d_ill;
    logic [IB_W-1:0] d_ib;
    logic            accept;

    assign cls      = ins[15:13];
    assign in_ready = (~out_valid | out_ready) & (state == RUN) & ~flush;
    assign accept   = in_valid & in_ready;
    assign halted   = state == HALTED;

    // combinational decode of the offered word; unset fields stay 0
    always_comb begin
        d_aradr   = 2'd0;
        d_bradr   = 2'd0;
        d_wadr    = 2'd0;
        d_op      = 3'd0;
        d_we      = 1'b0;
        d_halt    = 1'b0;
        d_ll      = 1'b0;
        d_lh      = 1'b0;
        d_use_imm = 1'b0;
        d_ill     = 1'b0;
        d_ib      = '0;
        if (cls == 3'b000) begin
            if (ins[2]) begin
                d_wadr  = ins[11:10];
                d_aradr = ins[9:8];
                d_op    = ins[6:4];
                d_bradr = ins[1:0];
                d_we    = 1'b1;
            end else begin
                d_halt  = ins[0];
            end
        end
`ifdef DEC_PIPE_IMM_EN
        else if (cls == 3'b001) begin
            d_wadr    = ins[11:10];
            d_aradr   = ins[11:10];
            d_op      = {ins[12], ins[9:8]};
            d_use_imm = 1'b1;
            d_we      = 1'b1;
            d_ib      = IB_W'($signed(ins[7:0]));
        end else if (cls == 3'b010) begin
            d_wadr = ins[11:10];
            d_we   = 1'b1;
            d_ib   = IB_W'(ins[7:0]);
            d_ll   = ~ins[12];
            d_lh   = ins[12];
        end
`else
        else if (cls == 3'b001 || cls == 3'b010) begin
            d_ill = 1'b1;
        end
`endif
        else begin
            d_ill = 1'b1;
        end
    end

    // control FSM: a halt (or illegal, if configured) word drains, then halts once consumed
    always_comb begin
        state_nx = state;
        if (state == RUN)
            state_nx = (accept & (d_halt | ((ILL_HALT != 0) & d_ill))) ? DRAIN : RUN;
        else if (state == DRAIN)
            state_nx = flush ? RUN : (out_valid & out_ready) ? HALTED : DRAIN;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    // output stage: load on accept, drop on consume or flush, illegal is sticky
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            aradr     <= 2'd0;
            bradr     <= 2'd0;
            wadr      <= 2'd0;
            op        <= 3'd0;
            we        <= 1'b0;
            halt      <= 1'b0;
            ll        <= 1'b0;
            lh        <= 1'b0;
            use_imm   <= 1'b0;
            ib        <= '0;
        end else begin
            if (flush && state != HALTED) out_valid <= 1'b0;
            else if (accept)              out_valid <= 1'b1;
            else if (out_ready)           out_valid <= 1'b0;
            if (accept) begin
                illegal <= illegal | d_ill;
                aradr   <= d_aradr;
                bradr   <= d_bradr;
                wadr    <= d_wadr;
                op      <= d_op;
                we      <= d_we;
                halt    <= d_halt;
                ll      <= d_ll;
                lh      <= d_lh;
                use_imm <= d_use_imm;
                ib      <= d_ib;
            end
        end
    end
endmodule

// File: tb/tb_dec_pipe.sv
// tb_dec_pipe: directed self-checking bench for dec_pipe (two instances: ILL_HALT=0 with IB_W=16, ILL_HALT=1 default width)
module tb_dec_pipe;
    logic        clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [15:0] ins = 16'h0;
    logic        in_ready, out_valid, we, halt, ll, lh, use_imm, halted, illegal;
    logic [1:0]  aradr, bradr, wadr;
    logic [2:0]  op;
    logic [15:0] ib;
    logic        in_ready1, out_valid1, we1, halt1, ll1, lh1, use_imm1, halted1, illegal1;
    logic [1:0]  aradr1, bradr1, wadr1;
    logic [2:0]  op1;
    logic [7:0]  ib1;
    int          n_chk = 0, n_fail = 0;

    dec_pipe #(.IB_W(16), .ILL_HALT(0)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ins(ins), .out_valid(out_valid), .out_ready(out_ready), .aradr(aradr), .bradr(bradr),
        .wadr(wadr), .op(op), .we(we), .halt(halt), .ll(ll), .lh(lh), .use_imm(use_imm),
        .ib(ib), .halted(halted), .illegal(illegal));

    dec_pipe #(.IB_W(8), .ILL_HALT(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .ins(ins), .out_valid(out_valid1), .out_ready(out_ready), .aradr(aradr1), .bradr(bradr1),
        .wadr(wadr1), .op(op1), .we(we1), .halt(halt1), .ll(ll1), .lh(lh1), .use_imm(use_imm1),
        .ib(ib1), .halted(halted1), .illegal(illegal1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1;
        #3 rst = 0;
        #1;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_ib", 32'(ib), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        // register ALU then NOP streamed
        in_valid = 1; out_ready = 1; ins = 16'h0E57;
        tick();
        chk("alu_valid", 32'(out_valid), 1);
        chk("alu_fields", {wadr, aradr, op, bradr, we}, {2'd3, 2'd2, 3'd5, 2'd3, 1'b1});
        ins = 16'h0000;
        tick();
        chk("nop_valid", 32'(out_valid), 1);
        chk("nop_fields", {wadr, aradr, op, bradr, we, halt, ib}, 0);
        in_valid = 0;
        tick();
        chk("idle_valid", 32'(out_valid), 0);
        // backpressure for 3 cycles
        in_valid = 1; out_ready = 0; ins = 16'h0E57;
        tick();
        ins = 16'h0D26;
        for (int i = 0; i < 3; i++) begin
            chk("bp_fields", {out_valid, wadr, aradr, op, bradr}, {1'b1, 2'd3, 2'd2, 3'd5, 2'd3});
            chk("bp_in_ready", 32'(in_ready), 0);
            tick();
        end
        out_ready = 1;
        #1 chk("bp_release_ready", 32'(in_ready), 1);
        tick();
        chk("bp_next_fields", {out_valid, wadr, aradr, op, bradr}, {1'b1, 2'd3, 2'd1, 3'd2, 2'd2});
        in_valid = 0;
        tick();
        // immediate classes
        in_valid = 1; ins = 16'h3480;
        tick();
`ifdef DEC_PIPE_IMM_EN
        chk("imm_alu", {use_imm, op, wadr, aradr, we, illegal}, {1'b1, 3'd4, 2'd1, 2'd1, 1'b1, 1'b0});
        chk("imm_ib", 32'(ib), 32'hFF80);
        ins = 16'h5480;
        tick();
        chk("ldi_fields", {lh, ll, wadr, we, use_imm}, {1'b1, 1'b0, 2'd1, 1'b1, 1'b0});
        chk("ldi_ib", 32'(ib), 32'h0080);
`else
        chk("imm_off_illegal", {illegal, out_valid, use_imm, we}, {1'b1, 1'b1, 1'b0, 1'b0});
        ins = 16'h5480;
        tick();
        chk("ldi_off_fields", {lh, ll, we, ib}, 0);
`endif
        in_valid = 0;
        tick();
        // halt word followed by an ALU word
        do_reset();
        in_valid = 1; ins = 16'h0001;
        tick();
        chk("halt_out", {out_valid, halt, we, in_ready, halted}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        ins = 16'h0E57;
        tick();
        chk("halted_state", {halted, in_ready, out_valid}, {1'b1, 1'b0, 1'b0});
        flush = 1;
        tick();
        tick();
        flush = 0;
        #1 chk("halted_sticky", {halted, in_ready, out_valid}, {1'b1, 1'b0, 1'b0});
        in_valid = 0;
        do_reset();
        chk("halt_cleared", {halted, in_ready}, {1'b0, 1'b1});
        // flush a held halt word in DRAIN
        in_valid = 1; out_ready = 0; ins = 16'h0001;
        tick();
        chk("drain_hold", {out_valid, halt, in_ready}, {1'b1, 1'b1, 1'b0});
        in_valid = 0; flush = 1;
        #1 chk("flush_blocks", 32'(in_ready), 0);
        tick();
        flush = 0;
        #1 chk("flush_result", {out_valid, halted, in_ready}, {1'b0, 1'b0, 1'b1});
        in_valid = 1; out_ready = 1; ins = 16'h0E57;
        tick();
        chk("post_flush_accept", {out_valid, we, op}, {1'b1, 1'b1, 3'd5});
        in_valid = 0;
        tick();
        // illegal class, sticky; ILL_HALT instance halts
        do_reset();
        in_valid = 1; ins = 16'hE000;
        tick();
        chk("ill_set", {illegal, out_valid, we, halt}, {1'b1, 1'b1, 1'b0, 1'b0});
        chk("ill1_drain", {illegal1, in_ready1, halted1}, {1'b1, 1'b0, 1'b0});
        ins = 16'h0E57;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("ill_sticky", {illegal, out_valid, we}, {1'b1, 1'b1, 1'b1});
        end
        chk("ill1_halted", {halted1, in_ready1, out_valid1}, {1'b1, 1'b0, 1'b0});
        // reset mid-handshake discards the held word
        out_ready = 0;
        do_reset();
        tick();
        chk("mid_load", 32'(out_valid), 1);
        in_valid = 0;
        #1 rst = 1;
        #1 chk("async_rst", {out_valid, illegal, we, op}, 0);
        rst = 0;
        out_ready = 1;
        tick();
        chk("no_reappear", {out_valid, we}, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
